// File: rtl/pwm_pkg.sv
// Constants and FSM encoding shared by the PWM duty meter and the duty-variator generator.
package pwm_pkg;

  localparam int unsigned DUTY_STEPS = 10;
  localparam int unsigned DUTY_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/pwm_duty_meter_if.sv
// Measurement bundle: PWM line in, duty/period/stuck results out.
interface pwm_duty_meter_if #(
  parameter int unsigned CNT_W = 8
);

  logic                        pwm;
  logic [pwm_pkg::DUTY_W-1:0]  duty;
  logic [CNT_W-1:0]            period;
  logic                        valid;
  logic                        stuck;

  modport master (
    input  pwm,
    output duty,
    output period,
    output valid,
    output stuck
  );

  modport slave (
    output pwm,
    input  duty,
    input  period,
    input  valid,
    input  stuck
  );

endinterface

// File: rtl/pwm_div.sv
// Serial restoring divider: one quotient bit per cycle, MSB first, fixed DUTY_W-cycle latency.
module pwm_div
  import pwm_pkg::*;
#(
  parameter int unsigned NW = 12,
  parameter int unsigned DW = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              start,
  input  logic [NW-1:0]     n,
  input  logic [DW-1:0]     d,
  output logic [DUTY_W-1:0] quotient,
  output logic              done
);

  localparam logic [1:0] LAST_ITER = 2'(DUTY_W - 1);

  logic [NW-1:0]       rem;
  logic [NW-1:0]       dsr;
  logic [DUTY_W-2:0]   q;
  logic [1:0]          iter;
  logic                busy;
  logic                ge;

  // Quotient is exposed with the current bit already folded in, so the
  // caller can register the final value on the last iteration's edge.
  assign ge       = (rem >= dsr);
  assign quotient = {q, ge};
  assign done     = busy & (iter == LAST_ITER);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rem  <= '0;
      dsr  <= '0;
      q    <= '0;
      iter <= '0;
      busy <= 1'b0;
    end else if (start) begin
      rem  <= n;
      dsr  <= NW'(d) << (DUTY_W - 1);
      q    <= '0;
      iter <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      if (ge) rem <= rem - dsr;
      dsr  <= dsr >> 1;
      q    <= quotient[DUTY_W-2:0];
      iter <= iter + 2'd1;
      if (iter == LAST_ITER) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures period and high time of an external PWM line and reports duty in tenths,
// with a saturating watchdog that flags lines stuck at 0 % or 100 %.
module pwm_duty_meter
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  pwm_duty_meter_if.master  bus
);

  localparam int unsigned     NW      = CNT_W + 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]        sync;
  logic              s;
  logic              s_d;
  logic              rise;
  logic [CNT_W-1:0]  per_cnt;
  logic [CNT_W-1:0]  hi_cnt;
  logic [CNT_W-1:0]  p_hold;
  logic              armed;
  logic              stuck_seen;
  state_e            state;
  logic              capture;
  logic              stuck_hit;
  logic [NW-1:0]     div_n;
  logic [DUTY_W-1:0] div_q;
  logic              div_done;
  logic [DUTY_W-1:0] duty_q;
  logic [CNT_W-1:0]  period_q;
  logic              valid_q;
  logic              stuck_q;

  assign s    = sync[1];
  assign rise = s & ~s_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[0], bus.pwm};
      s_d  <= sync[1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (rise) begin
      per_cnt <= CNT_W'(1);
      hi_cnt  <= CNT_W'(1);
    end else begin
      if (per_cnt != CNT_MAX)      per_cnt <= per_cnt + CNT_W'(1);
      if (s && hi_cnt != CNT_MAX)  hi_cnt  <= hi_cnt + CNT_W'(1);
    end
  end

  // Rises that arrive while a division is in flight only restart the counters.
  assign capture   = rise & armed & (state == IDLE);
  assign stuck_hit = ~rise & (per_cnt == CNT_MAX) & ~stuck_seen & (state == IDLE);

  // Adding P/2 before dividing rounds the tenths half-up.
  assign div_n = NW'(hi_cnt) * NW'(DUTY_STEPS) + NW'(per_cnt >> 1);

  pwm_div #(
    .NW (NW),
    .DW (CNT_W)
  ) u_div (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .start    (capture),
    .n        (div_n),
    .d        (per_cnt),
    .quotient (div_q),
    .done     (div_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      armed      <= 1'b0;
      stuck_seen <= 1'b0;
      p_hold     <= '0;
      duty_q     <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      stuck_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (rise) begin
        stuck_seen <= 1'b0;
        if (!armed) armed <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (capture) begin
            state  <= DIV;
            p_hold <= per_cnt;
          end else if (stuck_hit) begin
            stuck_q    <= 1'b1;
            duty_q     <= s ? DUTY_W'(DUTY_STEPS) : '0;
            period_q   <= CNT_MAX;
            valid_q    <= 1'b1;
            armed      <= 1'b0;
            stuck_seen <= 1'b1;
          end
        end
        DIV: begin
          if (div_done) begin
            state    <= DONE;
            duty_q   <= div_q;
            period_q <= p_hold;
            stuck_q  <= 1'b0;
            valid_q  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.duty   = duty_q;
  assign bus.period = period_q;
  assign bus.valid  = valid_q;
  assign bus.stuck  = stuck_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Random and directed PWM waveforms checked cycle-by-cycle against a timeline model of the meter.
module tb_pwm_duty_meter;

  localparam int unsigned CNT_W = 8;
  localparam int          MAXC  = 255;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  pwm_duty_meter_if #(.CNT_W(CNT_W)) bus ();

  pwm_duty_meter #(.CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: cycle index since reset release, time of last rise, high-cycle tally.
  int cyc, last_rise, hcnt, busy_end, armed, reported;
  int ff1, ff2, s_prev;
  int exp_valid, exp_duty, exp_period, exp_stuck;
  int res_due, res_duty, res_per, stuck_due, stuck_duty;

  task automatic check_eq(input string tag, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", tag, cyc, got, want);
    end
  endtask

  task automatic model_reset();
    cyc = 0; last_rise = 0; hcnt = 0; busy_end = -1000; armed = 0; reported = 0;
    ff1 = 0; ff2 = 0; s_prev = 0;
    exp_valid = 0; exp_duty = 0; exp_period = 0; exp_stuck = 0;
    res_due = -1; res_duty = 0; res_per = 0; stuck_due = -1; stuck_duty = 0;
  endtask

  task automatic check_outputs();
    check_eq("valid",  int'(bus.valid),  exp_valid);
    check_eq("duty",   int'(bus.duty),   exp_duty);
    check_eq("period", int'(bus.period), exp_period);
    check_eq("stuck",  int'(bus.stuck),  exp_stuck);
  endtask

  task automatic step(input logic p);
    int s, per;
    bus.pwm = p;
    @(posedge clk);
    #1;
    cyc++;
    exp_valid = 0;
    if (res_due == cyc) begin
      exp_valid = 1; exp_duty = res_duty; exp_period = res_per; exp_stuck = 0; res_due = -1;
    end
    if (stuck_due == cyc) begin
      exp_valid = 1; exp_duty = stuck_duty; exp_period = MAXC; exp_stuck = 1; stuck_due = -1;
    end
    check_outputs();
    // Line level as seen after two synchroniser stages.
    ff2 = ff1;
    ff1 = int'(p);
    s   = ff2;
    per = cyc - last_rise;
    if (per > MAXC) per = MAXC;
    if (s == 1 && s_prev == 0) begin
      if (armed == 0) begin
        armed = 1;
      end else if (cyc > busy_end) begin
        res_due  = cyc + 5;
        res_duty = (hcnt * 10 + per / 2) / per;
        res_per  = per;
        busy_end = cyc + 5;
      end
      last_rise = cyc;
      hcnt      = 1;
      reported  = 0;
    end else begin
      if (per == MAXC && reported == 0 && cyc > busy_end) begin
        stuck_due  = cyc + 1;
        stuck_duty = (s == 1) ? 10 : 0;
        armed      = 0;
        reported   = 1;
      end
      if (s == 1 && hcnt < MAXC) hcnt++;
    end
    s_prev = s;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic pwm_period(input int p, input int h);
    for (int i = 0; i < h; i++) step(1'b1);
    for (int i = 0; i < p - h; i++) step(1'b0);
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  initial begin
    bus.pwm = 1'b0;
    #2;
    do_reset();

    // Steady 50 % and a sweep of high times at a 10-cycle period.
    for (int i = 0; i < 12; i++) pwm_period(10, 5);
    for (int h = 1; h <= 9; h++) begin
      pwm_period(10, h);
      pwm_period(10, h);
    end
    for (int i = 0; i < 5; i++) pwm_period(7, 2);

    // Short periods where every other rise lands on a busy divider.
    for (int i = 0; i < 10; i++) pwm_period(3, 1);
    for (int i = 0; i < 8; i++) pwm_period(2, 1);
    for (int i = 0; i < 8; i++) pwm_period(4, $urandom_range(3, 1));

    // Random waveforms, periods long enough to be measured every time.
    for (int i = 0; i < 40; i++) begin
      int p;
      p = int'($urandom_range(40, 6));
      pwm_period(p, int'($urandom_range(p - 1, 1)));
    end

    // Reset while a division is in flight, then recovery.
    hold(1'b0, 6);
    hold(1'b1, 4);
    do_reset();
    for (int i = 0; i < 4; i++) pwm_period(10, 6);

    // Stuck low from reset, stuck high, then pulses resume.
    do_reset();
    hold(1'b0, 300);
    hold(1'b1, 300);
    hold(1'b0, 3);
    for (int i = 0; i < 5; i++) pwm_period(10, 4);

    // Stuck high straight out of reset.
    do_reset();
    hold(1'b1, 300);
    for (int i = 0; i < 3; i++) pwm_period(12, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
